// File: rtl/rf_wport_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter: widths, the r0 constant
// and the buffered writeback entry.
package rf_wport_arbiter_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;

  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic              live;
    logic [REG_W-1:0]  wn;
    logic [DATA_W-1:0] d;
  } fifo_entry_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Circular buffer for long-latency writebacks; entries can be killed in place by
// register number so a newer main-pipeline write wins.
module rf_wb_fifo
  import rf_wport_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       clrn,
  input  logic                       push,
  input  fifo_entry_t                push_entry,
  input  logic                       pop,
  input  logic                       squash,
  input  logic [REG_W-1:0]           squash_wn,
  output fifo_entry_t                head,
  output logic [$clog2(DEPTH):0]     count,
  output logic [DEPTH-1:0]           ent_occ,
  output logic [DEPTH-1:0]           ent_live,
  output logic [REG_W-1:0]           ent_wn [DEPTH]
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fifo_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_q, wr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [PTR_W-1:0]   off;

  always_ff @(posedge clk) begin
    if (!clrn) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i].live <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (squash && mem_q[i].wn == squash_wn) mem_q[i].live <= 1'b0;
      end
      // The pushed entry already accounts for this cycle's squash.
      if (push) begin
        mem_q[wr_q] <= push_entry;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_comb begin
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off         = PTR_W'(i) - rd_q;
      ent_occ[i]  = ({1'b0, off} < cnt_q);
      ent_live[i] = mem_q[i].live;
      ent_wn[i]   = mem_q[i].wn;
    end
  end

  assign head  = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/rf_wport_arbiter.sv
// Arbitrates the register-file write port between the main pipeline (A) and a
// buffered long-latency source (B), with a starvation stall and pending flags.
module rf_wport_arbiter
  import rf_wport_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic                   clk,
  input  logic                   clrn,
  input  logic                   a_we,
  input  logic [REG_W-1:0]       a_wn,
  input  logic [DATA_W-1:0]      a_d,
  input  logic                   b_valid,
  output logic                   b_ready,
  input  logic [REG_W-1:0]       b_wn,
  input  logic [DATA_W-1:0]      b_d,
  output logic                   stall_a,
  output logic                   rf_we,
  output logic [REG_W-1:0]       rf_wn,
  output logic [DATA_W-1:0]      rf_d,
  input  logic [REG_W-1:0]       rna,
  input  logic [REG_W-1:0]       rnb,
  output logic                   pend_a,
  output logic                   pend_b,
  output logic [$clog2(DEPTH):0] fifo_cnt
);

  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  fifo_entry_t        head;
  fifo_entry_t        push_entry;
  logic [CNT_W-1:0]   cnt;
  logic [DEPTH-1:0]   ent_occ, ent_live;
  logic [REG_W-1:0]   ent_wn [DEPTH];
  logic [WAIT_W-1:0]  wait_q, wait_d;

  logic a_act, head_live, stall, a_grant, head_grant, pop;
  logic can_push, hs, enq, pend_a_raw, pend_b_raw;

  assign a_act      = a_we & (a_wn != REG_ZERO);
  assign head_live  = (cnt != '0) & head.live;
  assign stall      = head_live & (wait_q == WAIT_W'(MAX_WAIT));
  assign a_grant    = a_act & ~stall;
  assign head_grant = head_live & ~a_grant;
  // A killed head drains one per cycle without using the port.
  assign pop        = (cnt != '0) & (head_grant | ~head.live);

  assign can_push   = (cnt < CNT_W'(DEPTH));
  assign hs         = b_valid & can_push & clrn;
  assign enq        = hs & (b_wn != REG_ZERO) & ~(a_grant & (b_wn == a_wn));
  assign push_entry = '{live: 1'b1, wn: b_wn, d: b_d};

  rf_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .clrn       (clrn),
    .push       (enq),
    .push_entry (push_entry),
    .pop        (pop),
    .squash     (a_grant),
    .squash_wn  (a_wn),
    .head       (head),
    .count      (cnt),
    .ent_occ    (ent_occ),
    .ent_live   (ent_live),
    .ent_wn     (ent_wn)
  );

  always_comb begin
    wait_d = wait_q;
    if (!head_live || head_grant) begin
      wait_d = '0;
    end else if (wait_q != WAIT_W'(MAX_WAIT)) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) wait_q <= '0;
    else       wait_q <= wait_d;
  end

  always_comb begin
    pend_a_raw = 1'b0;
    pend_b_raw = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_occ[i] && ent_live[i] && ent_wn[i] == rna) pend_a_raw = 1'b1;
      if (ent_occ[i] && ent_live[i] && ent_wn[i] == rnb) pend_b_raw = 1'b1;
    end
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_wn    = '0;
    rf_d     = '0;
    b_ready  = 1'b0;
    stall_a  = 1'b0;
    pend_a   = 1'b0;
    pend_b   = 1'b0;
    fifo_cnt = '0;
    if (clrn) begin
      b_ready  = can_push;
      stall_a  = stall;
      pend_a   = pend_a_raw & (rna != REG_ZERO);
      pend_b   = pend_b_raw & (rnb != REG_ZERO);
      fifo_cnt = cnt;
      if (a_grant) begin
        rf_we = 1'b1;
        rf_wn = a_wn;
        rf_d  = a_d;
      end else if (head_grant) begin
        rf_we = 1'b1;
        rf_wn = head.wn;
        rf_d  = head.d;
      end
    end
  end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed bench: each cycle's expected register-file write is queued by the
// stimulus; a negedge monitor matches actual writes against the queue.
module tb_rf_wport_arbiter;

  logic        clk = 1'b0;
  logic        clrn;
  logic        a_we, b_valid, b_ready, stall_a, rf_we, pend_a, pend_b;
  logic [4:0]  a_wn, b_wn, rf_wn, rna, rnb;
  logic [31:0] a_d, b_d, rf_d;
  logic [2:0]  fifo_cnt;

  typedef struct {
    logic [4:0]  wn;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  always #5 clk = ~clk;

  rf_wport_arbiter #(
    .DEPTH    (4),
    .MAX_WAIT (3)
  ) dut (
    .clk      (clk),
    .clrn     (clrn),
    .a_we     (a_we),
    .a_wn     (a_wn),
    .a_d      (a_d),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_wn     (b_wn),
    .b_d      (b_d),
    .stall_a  (stall_a),
    .rf_we    (rf_we),
    .rf_wn    (rf_wn),
    .rf_d     (rf_d),
    .rna      (rna),
    .rnb      (rnb),
    .pend_a   (pend_a),
    .pend_b   (pend_b),
    .fifo_cnt (fifo_cnt)
  );

  // Monitor: every write must match the head of the queue; a queued write the
  // DUT did not perform this cycle is a miss.
  always @(negedge clk) begin
    wr_t e;
    if (rf_we) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got wn=%0d d=%h, required no write", rf_wn, rf_d);
      end else begin
        e = exp_q.pop_front();
        if (rf_wn !== e.wn || rf_d !== e.d) begin
          bad++;
          $display("FAIL write_data: got wn=%0d d=%h, required wn=%0d d=%h",
                   rf_wn, rf_d, e.wn, e.d);
        end
      end
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      e = exp_q.pop_front();
      $display("FAIL missing_write: got no write, required wn=%0d d=%h", e.wn, e.d);
      exp_q.delete();
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [4:0] wn, input logic [31:0] d);
    wr_t e;
    e.wn = wn;
    e.d  = d;
    exp_q.push_back(e);
  endtask

  // Called just after a rising edge; leaves time for combinational outputs to settle.
  task automatic drive(input logic awe, input logic [4:0] awn, input logic [31:0] ad,
                       input logic bv, input logic [4:0] bwn, input logic [31:0] bd);
    a_we    = awe;
    a_wn    = awn;
    a_d     = ad;
    b_valid = bv;
    b_wn    = bwn;
    b_d     = bd;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  initial begin
    clrn = 1'b0;
    rna  = 5'd0;
    rnb  = 5'd0;
    idle();
    step();
    idle();
    check("reset_rf_we", {31'b0, rf_we}, 32'd0);
    check("reset_b_ready", {31'b0, b_ready}, 32'd0);
    check("reset_fifo_cnt", {29'b0, fifo_cnt}, 32'd0);
    step();
    clrn = 1'b1;
    idle();
    check("idle_b_ready", {31'b0, b_ready}, 32'd1);
    step();

    // Idle A: B result written one cycle after acceptance.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    step();
    idle();
    expect_wr(5'd5, 32'hDEAD_BEEF);
    check("b_lat_cnt", {29'b0, fifo_cnt}, 32'd1);
    step();
    idle();
    check("b_lat_drain", {29'b0, fifo_cnt}, 32'd0);
    step();

    // Starvation: A wins three times, then the stall hands the port to wn=7.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h77);
    step();
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 5'd3, 32'h30 + i, 1'b0, 5'd0, 32'h0);
      expect_wr(5'd3, 32'h30 + i);
      check("starve_no_stall", {31'b0, stall_a}, 32'd0);
      step();
    end
    drive(1'b1, 5'd3, 32'h34, 1'b0, 5'd0, 32'h0);
    expect_wr(5'd7, 32'h77);
    check("starve_stall", {31'b0, stall_a}, 32'd1);
    step();
    drive(1'b1, 5'd3, 32'h34, 1'b0, 5'd0, 32'h0);
    expect_wr(5'd3, 32'h34);
    check("starve_resume", {31'b0, stall_a}, 32'd0);
    step();

    // Squash: A writes r9 while r9 is buffered and another r9 result arrives.
    rna = 5'd9;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99);
    step();
    drive(1'b1, 5'd9, 32'h1, 1'b1, 5'd9, 32'h98);
    expect_wr(5'd9, 32'h1);
    check("squash_pend_before", {31'b0, pend_a}, 32'd1);
    check("squash_b_ready", {31'b0, b_ready}, 32'd1);
    step();
    idle();
    check("squash_pend_after", {31'b0, pend_a}, 32'd0);
    check("squash_killed_cnt", {29'b0, fifo_cnt}, 32'd1);
    step();
    idle();
    check("squash_drained", {29'b0, fifo_cnt}, 32'd0);
    step();
    rna = 5'd0;

    // Full: four pushes while A keeps the port busy.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'd20, 32'hB0 + i, 1'b1, 5'd10 + i, 32'hA0 + i);
      expect_wr(5'd20, 32'hB0 + i);
      step();
    end
    rnb = 5'd13;
    drive(1'b1, 5'd20, 32'hB4, 1'b1, 5'd14, 32'hEE);
    expect_wr(5'd10, 32'hA0);
    check("full_cnt", {29'b0, fifo_cnt}, 32'd4);
    check("full_b_ready", {31'b0, b_ready}, 32'd0);
    check("full_stall", {31'b0, stall_a}, 32'd1);
    check("full_pend_b", {31'b0, pend_b}, 32'd1);
    check("full_pend_a_r0", {31'b0, pend_a}, 32'd0);
    step();
    drive(1'b1, 5'd20, 32'hB4, 1'b0, 5'd0, 32'h0);
    expect_wr(5'd20, 32'hB4);
    check("after_pop_cnt", {29'b0, fifo_cnt}, 32'd3);
    step();
    // A write to r0 is not a request: the head takes the port.
    drive(1'b1, 5'd0, 32'h5555, 1'b0, 5'd0, 32'h0);
    expect_wr(5'd11, 32'hA1);
    step();
    // A B result for r0 handshakes but is not buffered.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1234);
    expect_wr(5'd12, 32'hA2);
    check("r0_b_ready", {31'b0, b_ready}, 32'd1);
    step();
    idle();
    expect_wr(5'd13, 32'hA3);
    check("r0_not_enqueued", {29'b0, fifo_cnt}, 32'd1);
    step();
    idle();
    check("full_drained", {29'b0, fifo_cnt}, 32'd0);
    rnb = 5'd0;
    step();

    // Reset mid-operation: three buffered writes must vanish.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd1, 32'h11 + i, 1'b1, 5'd21 + i, 32'hC1 + i);
      expect_wr(5'd1, 32'h11 + i);
      step();
    end
    rna  = 5'd21;
    check("pre_reset_cnt", {29'b0, fifo_cnt}, 32'd3);
    clrn = 1'b0;
    idle();
    check("mid_reset_cnt", {29'b0, fifo_cnt}, 32'd0);
    check("mid_reset_rf_we", {31'b0, rf_we}, 32'd0);
    check("mid_reset_pend_a", {31'b0, pend_a}, 32'd0);
    check("mid_reset_stall", {31'b0, stall_a}, 32'd0);
    step();
    clrn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idle();
      step();
    end
    idle();
    check("post_reset_cnt", {29'b0, fifo_cnt}, 32'd0);
    check("post_reset_pend_a", {31'b0, pend_a}, 32'd0);
    step();
    check("queue_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_wport_arbiter.md
Name: rf_wport_arbiter

Overview:
- Shares the single write port of the 32x32 register file between two writeback sources.
- Source A is the main pipeline writeback: it is never back-pressured except via the starvation stall.
- Source B is a long-latency unit (mult/div, multicycle load) with a valid/ready handshake, buffered in a small FIFO.
- Also drives per-read-port "pending" flags so the hazard logic can interlock on registers that still have a buffered B write.

Parameters:
- DEPTH, 4: FIFO entries for source B; power of two, >= 2.
- MAX_WAIT, 3: cycles a live FIFO head may lose arbitration before stall_a forces a grant; >= 1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- clrn  in  1  synchronous active-low reset.
- a_we  in  1  source A write request.
- a_wn  in  5  source A destination register.
- a_d  in  32  source A write data.
- b_valid  in  1  source B result valid.
- b_ready  out  1  FIFO can accept a B result.
- b_wn  in  5  source B destination register.
- b_d  in  32  source B write data.
- stall_a  out  1  pipeline must hold WB this cycle; the A write is not performed and must be re-presented.
- rf_we  out  1  register-file write enable.
- rf_wn  out  5  register-file write register.
- rf_d  out  32  register-file write data.
- rna  in  5  register-file read port A number (for the pending check).
- rnb  in  5  register-file read port B number (for the pending check).
- pend_a  out  1  a live buffered B write targets rna.
- pend_b  out  1  a live buffered B write targets rnb.
- fifo_cnt  out  $clog2(DEPTH)+1  occupancy, including killed entries.

Behaviour:
- State:
  - FIFO of DEPTH entries {live, wn, d}, with rd_ptr, wr_ptr and count.
  - wait_cnt, 0..MAX_WAIT.
- Reset: when clrn=0 at a rising edge, count, pointers, wait_cnt and all live bits are cleared. While clrn=0, all outputs are forced low: rf_we, b_ready, stall_a, pend_a, pend_b, fifo_cnt.
- Outputs are combinational from state plus inputs. stall_a and b_ready depend on state only, so there is no combinational loop.
- a_act = a_we & (a_wn != 0).
- head_live = (count != 0) & live[rd_ptr].
- stall_a = head_live & (wait_cnt == MAX_WAIT).
- Grant, priority order:
  - stall_a = 1: write the FIFO head; the A request is ignored.
  - a_act = 1: write A (rf_wn=a_wn, rf_d=a_d).
  - head_live = 1: write the FIFO head.
  - Otherwise: rf_we = 0.
- A latency is 0 (same-cycle write). B latency is >= 1 cycle after acceptance; there is no bypass.
- Pop: the head is popped when it is granted, or whenever the head is killed (a killed head pops without writing, one per cycle).
- Push:
  - b_valid & b_ready completes the handshake.
  - b_ready = (count < DEPTH). A same-cycle pop does not free a slot.
  - An entry is enqueued live only if b_wn != 0 and the B result is not squashed by this cycle's A write; otherwise the handshake completes with no enqueue.
- Squash: A is program-order newer than every B result presented in the same or an earlier cycle. When A is granted with wn = X:
  - every FIFO entry with wn == X has its live bit cleared;
  - an incoming B result with b_wn == X is dropped.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- wait_cnt:
  - cleared when the head is granted or head_live = 0;
  - otherwise increments, saturating at MAX_WAIT.
- pend_x = (rn_x != 0) & OR over i of (i occupied & live[i] & wn[i] == rn_x).

Decomposition:
- Shared package: REG_W=5, DATA_W=32, the zero-register constant, and the FIFO entry struct {live, wn, d}.
- One natural sub-module: rf_wb_fifo. It holds the storage, pointers and count, and exposes a per-entry wn/live view plus a squash-by-wn input.
- Arbitration, the wait counter and the pending compare stay in the top level.

Test Plan:
- Reset mid-operation: fill 3 entries, pulse clrn=0 for one cycle -> fifo_cnt=0, rf_we=0 during reset, pend_a=0, and none of the 3 values is ever written afterwards.
- Idle A: push B {wn=5, d=0xDEAD_BEEF} in cycle t -> rf_we=1, rf_wn=5, rf_d=0xDEADBEEF in cycle t+1; fifo_cnt returns to 0.
- Starvation: FIFO holds wn=7; a_we=1, a_wn=3 every cycle -> A wins 3 cycles, stall_a=1 on the 4th with rf_wn=7, and A resumes the next cycle.
- Squash: FIFO holds {wn=9}; A writes wn=9 with 0x1 -> the entry is killed and popped without a write; pend_a with rna=9 drops to 0; a same-cycle B push with b_wn=9 is accepted but never written.
- Full/r0: push DEPTH=4 entries -> b_ready=0 with fifo_cnt=4, even while a pop occurs. A push with b_wn=0 -> handshake completes, no enqueue. a_we=1 with a_wn=0 -> the FIFO head is granted.
